gb_frame_sequencer: RTL and testbench
=====================================

GB_FRAME_SEQUENCER -- requirements
Module: gb_frame_sequencer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 13, prescaler width; 4.194304 MHz / 2^13 gives a 512 Hz step tick.
REQ-002 SHALL have port clk, in, 1, system clock at 4.194304 MHz.
REQ-003 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-004 SHALL have port apu_enable, in, 1, APU master enable (NR52 bit 7).
REQ-005 SHALL have port div_reset, in, 1, one-cycle pulse for a CPU write to DIV.
REQ-006 SHALL have port div_bit, in, 1, external DIV tap; present only when FS_EXT_DIV_EN is defined.
REQ-007 SHALL have port clk_length_ctr, out, 1, 256 Hz one-cycle length-counter pulse to the channels.
REQ-008 SHALL have port clk_sweep, out, 1, 128 Hz one-cycle frequency-sweep pulse.
REQ-009 SHALL have port clk_vol_env, out, 1, 64 Hz one-cycle volume-envelope pulse.
REQ-010 SHALL have port step, out, 3, index of the next step to execute (0-7).

Function
REQ-011 Prescaler SHALL increment by 1 every clk, wrap from all-ones to 0, and run regardless of apu_enable.
REQ-012 A tick SHALL occur at the clk edge where prescaler[DIV_WIDTH-1] goes 1->0, whether by wrap or by div_reset.
REQ-013 div_reset sampled high SHALL clear the prescaler to 0 and SHALL produce a tick only if prescaler[DIV_WIDTH-1] was 1.
REQ-014 A div_reset coinciding with a natural wrap SHALL produce exactly one tick.
REQ-015 On a tick with apu_enable=1, outputs SHALL be registered from the current step value, and step SHALL then advance mod 8 (7->0).
REQ-016 Pulses SHALL be high for the single clk cycle following the tick edge and low in all other cycles.
REQ-017 clk_length_ctr SHALL pulse at steps 0, 2, 4 and 6.
REQ-018 clk_sweep SHALL pulse at steps 2 and 6.
REQ-019 clk_vol_env SHALL pulse at step 7 only.
REQ-020 While apu_enable=0, step SHALL be held at 0, all pulse outputs SHALL be 0, and ticks SHALL be ignored.
REQ-021 After apu_enable rises, the first tick SHALL execute step 0.
REQ-022 A tick in the same cycle that apu_enable falls SHALL be ignored.

Reset
REQ-023 reset low SHALL immediately force prescaler=0, step=0, all pulse outputs=0 and edge-history flops=0, independent of clk.
REQ-024 After reset deasserts, the first tick SHALL occur 2^DIV_WIDTH clk edges later and SHALL execute step 0.

Configuration
REQ-025 Macro FS_EXT_DIV_EN, when defined, SHALL remove the internal prescaler, add port div_bit, and ignore div_reset.
REQ-026 With FS_EXT_DIV_EN defined, a tick SHALL occur at the edge where registered div_bit_q=1 and sampled div_bit=0, giving one cycle of latency from the div_bit fall to the tick edge.
REQ-027 Without FS_EXT_DIV_EN, the block SHALL behave per REQ-011 to REQ-014 and SHALL have no div_bit port.

Structure
REQ-028 Package gb_apu_pkg SHALL hold: typedef fs_step_t (3-bit), FS_NUM_STEPS=8, FS_LEN_MASK=8'b0101_0101, FS_SWEEP_MASK=8'b0100_0100, FS_ENV_MASK=8'b1000_0000.
REQ-029 Pulse decode SHALL index these masks by step.
REQ-030 Sub-module gb_fs_prescaler SHALL contain the prescaler and falling-edge tick detect, exporting a one-cycle tick.

Verification (DIV_WIDTH=4)
REQ-031 Release reset with apu_enable=1 -> clk_length_ctr high for 1 cycle after edge 16; step goes to 1; clk_sweep and clk_vol_env stay 0.
REQ-032 Run 128 clk -> 4 clk_length_ctr pulses (steps 0,2,4,6), 2 clk_sweep pulses (2,6), 1 clk_vol_env pulse (7); step returns to 0.
REQ-033 Drop apu_enable at step 5, hold 64 clk, re-raise -> no pulses while low; step reads 0; next tick pulses clk_length_ctr (step 0).
REQ-034 div_reset at prescaler=9 -> prescaler 0 and tick next edge (extra pulse); div_reset at prescaler=3 -> prescaler 0, no pulse, next tick 16 edges later.
REQ-035 Assert reset mid-pulse at step 7 -> clk_vol_env drops without a clk edge; step=0 and prescaler=0.
REQ-036 FS_EXT_DIV_EN defined: div_bit 1->0 -> pulse one cycle after the tick edge; div_bit 0->1 -> no pulse; div_reset pulse -> no effect.

Source files
------------

// File: rtl/gb_apu_pkg.sv
// Shared types and step-decode masks for the APU frame sequencer.
// Build option: FS_EXT_DIV_EN (external DIV tap instead of internal prescaler).
package gb_apu_pkg;

  typedef logic [2:0] fs_step_t;

  localparam int FS_NUM_STEPS = 8;

  // Bit n set means the pulse fires when step n executes.
  localparam logic [7:0] FS_LEN_MASK   = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK   = 8'b1000_0000;

  function automatic fs_step_t fs_next_step(input fs_step_t s);
    return fs_step_t'((int'(s) + 1) % FS_NUM_STEPS);
  endfunction

endpackage

// File: rtl/gb_frame_sequencer_if.sv
// Control inputs and step pulses of the frame sequencer.
// Build option: FS_EXT_DIV_EN adds the div_bit tap.
interface gb_frame_sequencer_if;
  import gb_apu_pkg::*;

  logic     apu_enable;
  logic     div_reset;
`ifdef FS_EXT_DIV_EN
  logic     div_bit;
`endif
  logic     clk_length_ctr;
  logic     clk_sweep;
  logic     clk_vol_env;
  fs_step_t step;

`ifdef FS_EXT_DIV_EN
  modport master (output apu_enable, div_reset, div_bit,
                  input  clk_length_ctr, clk_sweep, clk_vol_env, step);
  modport slave  (input  apu_enable, div_reset, div_bit,
                  output clk_length_ctr, clk_sweep, clk_vol_env, step);
`else
  modport master (output apu_enable, div_reset,
                  input  clk_length_ctr, clk_sweep, clk_vol_env, step);
  modport slave  (input  apu_enable, div_reset,
                  output clk_length_ctr, clk_sweep, clk_vol_env, step);
`endif

endinterface

// File: rtl/gb_fs_prescaler.sv
// Step-tick source: falling edge of the prescaler MSB (or of an external
// DIV tap when FS_EXT_DIV_EN is defined). tick is combinational and is
// high in the cycle before the edge at which the step executes.
module gb_fs_prescaler #(
  parameter int DIV_WIDTH = 13
) (
  input  logic clk,
  input  logic reset,
`ifdef FS_EXT_DIV_EN
  input  logic div_bit,
`else
  input  logic div_reset,
`endif
  output logic tick
);

`ifdef FS_EXT_DIV_EN
  logic div_bit_q, div_bit_d;

  // Edge history of the external tap.
  always_comb div_bit_d = div_bit;

  // Tap history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_bit_q <= 1'b0;
    else        div_bit_q <= div_bit_d;
  end

  // Falling edge: registered 1, sampled 0.
  always_comb tick = div_bit_q & ~div_bit;
`else
  localparam logic [DIV_WIDTH-1:0] PRESC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] presc_q, presc_d;

  // Free-running count; a DIV write clears it, which may itself cause a tick.
  always_comb presc_d = div_reset ? '0 : presc_q + PRESC_ONE;

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  // MSB 1->0 across this edge; wrap and clear coincide into a single tick.
  always_comb tick = presc_q[DIV_WIDTH-1] & ~presc_d[DIV_WIDTH-1];
`endif

endmodule

// File: rtl/gb_frame_sequencer.sv
// Game Boy APU frame sequencer: 8-step cycle producing length (256 Hz),
// sweep (128 Hz) and envelope (64 Hz) one-cycle pulses.
// Build option: FS_EXT_DIV_EN uses an external DIV tap and ignores div_reset.
module gb_frame_sequencer
  import gb_apu_pkg::*;
#(
  parameter int DIV_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  gb_frame_sequencer_if.slave  fs
);

  logic     tick;
  fs_step_t step_q, step_d;
  logic     len_q, len_d;
  logic     sweep_q, sweep_d;
  logic     env_q, env_d;

  gb_fs_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
    .clk       (clk),
    .reset     (reset),
`ifdef FS_EXT_DIV_EN
    .div_bit   (fs.div_bit),
`else
    .div_reset (fs.div_reset),
`endif
    .tick      (tick)
  );

  // Decode the current step on a tick, then advance; disabled APU parks at step 0.
  always_comb begin
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!fs.apu_enable) begin
      step_d = '0;
    end else if (tick) begin
      len_d   = FS_LEN_MASK[step_q];
      sweep_d = FS_SWEEP_MASK[step_q];
      env_d   = FS_ENV_MASK[step_q];
      step_d  = fs_next_step(step_q);
    end
  end

  // Step and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q  <= '0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign fs.step           = step_q;
  assign fs.clk_length_ctr = len_q;
  assign fs.clk_sweep      = sweep_q;
  assign fs.clk_vol_env    = env_q;

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Self-checking bench for gb_frame_sequencer at DIV_WIDTH=4.
// Build option: FS_EXT_DIV_EN switches to the external-tap checks.
module tb_gb_frame_sequencer;

  localparam int W      = 4;
  localparam int PERIOD = 1 << W;

  logic clk = 1'b0;
  logic reset = 1'b0;

  gb_frame_sequencer_if fs ();

  gb_frame_sequencer #(.DIV_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (fs)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: prescaler value, next step, tap history, expected pulses.
  int m_presc = 0;
  int m_step  = 0;
  bit m_prev  = 1'b0;
  bit m_len, m_sweep, m_env;
  int n_len, n_sweep, n_env;

  typedef struct {
    bit en;
    int cycles;
    int e_len;
    int e_sweep;
    int e_env;
    int e_step;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model of one clock edge from the rules: tick when the divider's top bit falls.
  task automatic model_edge();
    bit tick;
`ifdef FS_EXT_DIV_EN
    tick   = m_prev && !fs.div_bit;
    m_prev = fs.div_bit;
`else
    int nxt;
    nxt     = fs.div_reset ? 0 : (m_presc + 1) % PERIOD;
    tick    = (m_presc >= PERIOD / 2) && (nxt < PERIOD / 2);
    m_presc = nxt;
`endif
    m_len   = fs.apu_enable && tick && (m_step % 2 == 0);
    m_sweep = fs.apu_enable && tick && (m_step % 4 == 2);
    m_env   = fs.apu_enable && tick && (m_step == 7);
    if (!fs.apu_enable) m_step = 0;
    else if (tick)      m_step = (m_step + 1) % 8;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("cyc_len",   int'(fs.clk_length_ctr), int'(m_len));
    check("cyc_sweep", int'(fs.clk_sweep),      int'(m_sweep));
    check("cyc_env",   int'(fs.clk_vol_env),    int'(m_env));
    check("cyc_step",  int'(fs.step),           m_step);
    n_len   += int'(fs.clk_length_ctr);
    n_sweep += int'(fs.clk_sweep);
    n_env   += int'(fs.clk_vol_env);
  endtask

  task automatic clr_counts();
    n_len = 0; n_sweep = 0; n_env = 0;
  endtask

  vec_t tbl [5];
  bit   found;

  initial begin
    tbl = '{
      '{1'b1,  16, 1, 0, 0, 1},
      '{1'b1, 112, 3, 2, 1, 0},
      '{1'b1,  80, 3, 1, 0, 5},
      '{1'b0,  64, 0, 0, 0, 0},
      '{1'b1,  16, 1, 0, 0, 1}
    };
    fs.apu_enable = 1'b1;
    fs.div_reset  = 1'b0;
`ifdef FS_EXT_DIV_EN
    fs.div_bit    = 1'b0;
`endif
    clr_counts();

    #12;
    check("rst_len",   int'(fs.clk_length_ctr), 0);
    check("rst_sweep", int'(fs.clk_sweep),      0);
    check("rst_env",   int'(fs.clk_vol_env),    0);
    check("rst_step",  int'(fs.step),           0);
    @(negedge clk);
    reset = 1'b1;

`ifndef FS_EXT_DIV_EN
    // Directed segments: pulse totals and final step are hand-derived.
    for (int i = 0; i < 5; i++) begin
      fs.apu_enable = tbl[i].en;
      clr_counts();
      repeat (tbl[i].cycles) cyc();
      check($sformatf("tbl%0d_len", i),   n_len,          tbl[i].e_len);
      check($sformatf("tbl%0d_sweep", i), n_sweep,        tbl[i].e_sweep);
      check($sformatf("tbl%0d_env", i),   n_env,          tbl[i].e_env);
      check($sformatf("tbl%0d_step", i),  int'(fs.step),  tbl[i].e_step);
    end

    // DIV write with the top bit set: immediate tick (step 1 -> 2).
    repeat (9) cyc();
    check("presc_at_9", int'(dut.u_presc.presc_q), 9);
    fs.div_reset = 1'b1;
    cyc();
    fs.div_reset = 1'b0;
    check("divrst9_step",  int'(fs.step), 2);
    check("divrst9_presc", int'(dut.u_presc.presc_q), 0);

    // DIV write with the top bit clear: no tick, next one a full period later.
    repeat (3) cyc();
    fs.div_reset = 1'b1;
    cyc();
    fs.div_reset = 1'b0;
    check("divrst3_step",  int'(fs.step), 2);
    check("divrst3_presc", int'(dut.u_presc.presc_q), 0);
    clr_counts();
    repeat (15) cyc();
    check("divrst3_quiet", n_len + n_sweep + n_env, 0);
    cyc();
    check("divrst3_len",   int'(fs.clk_length_ctr), 1);
    check("divrst3_sweep", int'(fs.clk_sweep), 1);
    check("divrst3_next",  int'(fs.step), 3);
`else
    // External tap: falling edge ticks, rising edge and DIV writes do nothing.
    fs.div_bit = 1'b1;
    repeat (2) cyc();
    check("ext_rise_step", int'(fs.step), 0);
    fs.div_bit = 1'b0;
    cyc();
    check("ext_fall_len",  int'(fs.clk_length_ctr), 1);
    check("ext_fall_step", int'(fs.step), 1);
    clr_counts();
    fs.div_bit = 1'b1;
    repeat (3) cyc();
    fs.div_reset = 1'b1;
    cyc();
    fs.div_reset = 1'b0;
    repeat (2) cyc();
    check("ext_quiet",   n_len + n_sweep + n_env, 0);
    check("ext_divrst_step", int'(fs.step), 1);
`endif

    // Reset in the middle of an envelope pulse.
    fs.apu_enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
`ifdef FS_EXT_DIV_EN
      fs.div_bit = ~fs.div_bit;
`endif
      cyc();
      if (fs.clk_vol_env) found = 1'b1;
    end
    check("env_wait", int'(found), 1);
    #2;
    reset = 1'b0;
    m_presc = 0; m_step = 0; m_prev = 1'b0;
    #1;
    check("midrst_env",  int'(fs.clk_vol_env), 0);
    check("midrst_step", int'(fs.step), 0);
`ifndef FS_EXT_DIV_EN
    check("midrst_presc", int'(dut.u_presc.presc_q), 0);
`else
    fs.div_bit = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
`ifndef FS_EXT_DIV_EN
    clr_counts();
    repeat (PERIOD - 1) cyc();
    check("postrst_quiet", n_len + n_sweep + n_env, 0);
    cyc();
    check("postrst_len",  int'(fs.clk_length_ctr), 1);
    check("postrst_step", int'(fs.step), 1);
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 40) == 0) fs.apu_enable = ~fs.apu_enable;
      fs.div_reset = ($urandom_range(0, 19) == 0);
`ifdef FS_EXT_DIV_EN
      if ($urandom_range(0, 2) == 0) fs.div_bit = ~fs.div_bit;
`endif
      cyc();
    end
    fs.div_reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
